// File: rtl/comp_save_sched.sv
// comp_save_sched: round-robin scheduler that reads data2 words out of the
// per-thread computation buffer and hands {thread, data2} to the memory input
// manager over a valid/ready handshake, reporting per-thread completion.
module comp_save_sched #(
    parameter int N_THREADS      = 16,
    parameter int N_THREADS_MSB  = $clog2(N_THREADS) - 1,
    parameter int COMP_DATA2_MSB = 31,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    req_en,
    input  logic [N_THREADS_MSB:0]  req_thread_num,
    output logic [N_THREADS_MSB:0]  rd_thread_num2,
    input  logic [COMP_DATA2_MSB:0] din2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_THREADS_MSB:0]  out_thread_num,
    output logic [COMP_DATA2_MSB:0] out_data,
    output logic                    done_en,
    output logic [N_THREADS_MSB:0]  done_thread_num,
    output logic                    busy,
    output logic                    err
);

    localparam int TW  = N_THREADS_MSB + 1;
    localparam int QAW = $clog2(QUEUE_DEPTH);
    localparam int CW  = QAW + 1;

    typedef logic [TW-1:0] thr_t;

    // Per-thread state: pending = requested, not yet granted;
    // inflight = granted, output not yet accepted. Never both set.
    logic [N_THREADS-1:0]  r_pending;
    logic [N_THREADS-1:0]  r_inflight;
    thr_t                  r_ptr;
    thr_t                  r_rd_thr;
    logic                  r_s1_vld;
    thr_t                  r_s1_thr;
    logic                  r_s2_vld;
    thr_t                  r_s2_thr;
    thr_t                  r_q_thr  [QUEUE_DEPTH];
    logic [COMP_DATA2_MSB:0] r_q_data [QUEUE_DEPTH];
    logic [QAW-1:0]        r_q_wp;
    logic [QAW-1:0]        r_q_rp;
    logic [CW-1:0]         r_q_cnt;
    logic                  r_done_en;
    thr_t                  r_done_thr;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_pop;
    logic                  w_push;
    thr_t                  w_head_thr;
    logic [CW:0]           w_occ;
    logic                  w_credit;
    logic                  w_found;
    thr_t                  w_sel;
    thr_t                  w_cand;
    logic                  w_gnt;
    logic                  w_dup;
    logic [N_THREADS-1:0]  w_pending_nxt;
    logic [N_THREADS-1:0]  w_inflight_nxt;

    assign w_pop      = (r_q_cnt != '0) & out_ready;
    assign w_push     = r_s2_vld;
    assign w_head_thr = r_q_thr[r_q_rp];

    // Every granted-but-unaccepted entry holds a credit, whether it is still
    // in the read pipeline or already queued, so the queue can never overflow.
    assign w_occ    = {1'b0, r_q_cnt} + (CW+1)'(r_s1_vld) + (CW+1)'(r_s2_vld);
    assign w_credit = (w_occ - (CW+1)'(w_pop)) < (CW+1)'(QUEUE_DEPTH);

    // Round-robin search: first pending thread strictly after the pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = 1; i <= N_THREADS; i++) begin
            w_cand = (r_ptr >= TW'(N_THREADS - i)) ? (r_ptr - TW'(N_THREADS - i))
                                                   : (r_ptr + TW'(i));
            if (!w_found && r_pending[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_gnt = w_found & w_credit;

    // A request is a duplicate if the thread is still pending or inflight as
    // sampled before this edge, which also covers the grant and done edges.
    assign w_dup = req_en & (r_pending[req_thread_num] | r_inflight[req_thread_num]);

    // Next per-thread state from done, grant and new request.
    always_comb begin
        w_pending_nxt  = r_pending;
        w_inflight_nxt = r_inflight;
        if (w_pop) begin
            w_inflight_nxt[w_head_thr] = 1'b0;
        end
        if (w_gnt) begin
            w_pending_nxt[w_sel]  = 1'b0;
            w_inflight_nxt[w_sel] = 1'b1;
        end
        if (req_en && !w_dup) begin
            w_pending_nxt[req_thread_num] = 1'b1;
        end
    end

    // Thread state, arbiter pointer and the buffer read address.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pending  <= '0;
            r_inflight <= '0;
            r_ptr      <= TW'(N_THREADS - 1);
            r_rd_thr   <= '0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_inflight <= w_inflight_nxt;
            if (w_gnt) begin
                r_ptr    <= w_sel;
                r_rd_thr <= w_sel;
            end
        end
    end

    // Two-stage tag pipeline matching the buffer's registered read latency.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_vld <= 1'b0;
            r_s1_thr <= '0;
            r_s2_vld <= 1'b0;
            r_s2_thr <= '0;
        end else begin
            r_s1_vld <= w_gnt;
            if (w_gnt) begin
                r_s1_thr <= w_sel;
            end
            r_s2_vld <= r_s1_vld;
            r_s2_thr <= r_s1_thr;
        end
    end

    // Output FIFO; push from stage 2 with the buffer word, pop on handshake.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_thr[i]  <= '0;
                r_q_data[i] <= '0;
            end
            r_q_wp  <= '0;
            r_q_rp  <= '0;
            r_q_cnt <= '0;
        end else begin
            if (w_push) begin
                r_q_thr[r_q_wp]  <= r_s2_thr;
                r_q_data[r_q_wp] <= din2;
                r_q_wp           <= r_q_wp + QAW'(1);
            end
            if (w_pop) begin
                r_q_rp <= r_q_rp + QAW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_q_cnt <= r_q_cnt + CW'(1);
                2'b01:   r_q_cnt <= r_q_cnt - CW'(1);
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end

    // Completion pulse, busy summary and sticky duplicate flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_done_en  <= 1'b0;
            r_done_thr <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done_en <= w_pop;
            if (w_pop) begin
                r_done_thr <= w_head_thr;
            end
            r_busy <= (|w_pending_nxt) | (|w_inflight_nxt);
            if (w_dup) begin
                r_err <= 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
        !(w_push && !w_pop && (r_q_cnt == CW'(QUEUE_DEPTH))));

    assign rd_thread_num2  = r_rd_thr;
    assign out_valid       = (r_q_cnt != '0);
    assign out_thread_num  = out_valid ? r_q_thr[r_q_rp]  : '0;
    assign out_data        = out_valid ? r_q_data[r_q_rp] : '0;
    assign done_en         = r_done_en;
    assign done_thread_num = r_done_thr;
    assign busy            = r_busy;
    assign err             = r_err;

endmodule

// File: tb/tb_comp_save_sched.sv
// Self-checking bench for comp_save_sched: transaction-level reference model
// (sets of pending/owned threads, round-robin pointer, ordered list of
// outstanding grants) plus an output scoreboard checked by a separate monitor.
module tb_comp_save_sched;

    localparam int NT = 16;
    localparam int QD = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        req_en;
    logic [3:0]  req_thread_num;
    logic [3:0]  rd_thread_num2;
    logic [31:0] din2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_thread_num;
    logic [31:0] out_data;
    logic        done_en;
    logic [3:0]  done_thread_num;
    logic        busy;
    logic        err;

    comp_save_sched #(.N_THREADS(NT), .COMP_DATA2_MSB(31), .QUEUE_DEPTH(QD)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_en(req_en), .req_thread_num(req_thread_num),
        .rd_thread_num2(rd_thread_num2), .din2(din2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_thread_num(out_thread_num), .out_data(out_data),
        .done_en(done_en), .done_thread_num(done_thread_num),
        .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    // Comp buffer data2 port: registered read.
    logic [31:0] mem [NT];
    always @(posedge CLK) din2 <= mem[rd_thread_num2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int thr; int gcyc; } ent_t;
    typedef struct { int thr; logic [31:0] data; } exp_t;

    ent_t oq[$];
    exp_t exp_q[$];
    int   seen_q[$];
    bit   m_pend [NT];
    bit   m_infl [NT];
    int   m_ptr, m_rd, m_cyc, m_done_thr;
    bit   m_err, m_done, m_busy;

    task automatic m_reset();
        for (int i = 0; i < NT; i++) begin
            m_pend[i] = 0;
            m_infl[i] = 0;
        end
        m_ptr = NT - 1; m_rd = 0; m_cyc = 0; m_done_thr = 0;
        m_err = 0; m_done = 0; m_busy = 0;
        oq.delete();
        exp_q.delete();
    endtask

    always @(negedge CLK) begin
        bit m_valid, pop, dup;
        int gnt, rt, outstanding;
        if (!RST_N) begin
            m_reset();
        end else begin
            m_valid = (oq.size() > 0) && (oq[0].gcyc + 2 <= m_cyc);
            check("rd_thread_num2", rd_thread_num2, m_rd);
            check("out_valid", out_valid, m_valid);
            check("done_en", done_en, m_done);
            if (m_done) check("done_thread_num", done_thread_num, m_done_thr);
            check("busy", busy, m_busy);
            check("err", err, m_err);

            rt  = int'(req_thread_num);
            pop = m_valid && out_ready;
            dup = req_en && (m_pend[rt] || m_infl[rt]);
            outstanding = oq.size() - int'(pop);
            gnt = -1;
            if (outstanding < QD) begin
                for (int i = 1; i <= NT; i++) begin
                    if (gnt < 0 && m_pend[(m_ptr + i) % NT]) gnt = (m_ptr + i) % NT;
                end
            end
            m_done = pop;
            if (pop) begin
                m_done_thr = oq[0].thr;
                m_infl[oq[0].thr] = 0;
                void'(oq.pop_front());
            end
            if (gnt >= 0) begin
                m_pend[gnt] = 0;
                m_infl[gnt] = 1;
                m_ptr = gnt;
                m_rd  = gnt;
                oq.push_back('{gnt, m_cyc + 1});
                exp_q.push_back('{gnt, mem[gnt]});
            end
            if (req_en) begin
                if (dup) m_err = 1;
                else     m_pend[rt] = 1;
            end
            m_cyc++;
            m_busy = 0;
            for (int i = 0; i < NT; i++) if (m_pend[i] || m_infl[i]) m_busy = 1;
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (RST_N && out_valid && out_ready) begin
            check("scoreboard_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("out_thread_num", out_thread_num, exp_q[0].thr);
                check("out_data", out_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            seen_q.push_back(int'(out_thread_num));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic req(int t);
        req_en = 1'b1;
        req_thread_num = 4'(t);
        tick();
        req_en = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        bit ok = 0;
        for (int c = 0; c < budget; c++) begin
            if (!m_busy && oq.size() == 0 && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("drain_within_budget", ok, 1);
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_done_en"}, done_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rd_thread_num2"}, rd_thread_num2, 0);
        check({tag, "_out_thread_num"}, out_thread_num, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_done_thread_num"}, done_thread_num, 0);
    endtask

    initial begin
        int base, lat, head0, cnt4, x;
        int ord[4] = '{0, 3, 7, 15};
        RST_N = 1'b0; req_en = 1'b0; req_thread_num = '0; out_ready = 1'b0;
        for (int i = 0; i < NT; i++) mem[i] = $urandom;
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        tick();

        // single request, thread 5
        out_ready = 1'b1;
        req(5);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) check("single_rd_thread_num2", rd_thread_num2, 5);
            if (out_valid && lat == 0) lat = k;
        end
        check("single_req_to_valid_latency", lat, 3);
        wait_idle(50);
        tick();
        check("single_busy_after", busy, 0);

        // burst 0,3,7,15
        base = seen_q.size();
        req(0); req(3); req(7); req(15);
        wait_idle(50);
        check("burst_count", seen_q.size() - base, 4);
        if (seen_q.size() - base == 4)
            for (int k = 0; k < 4; k++) check("burst_order", seen_q[base + k], ord[k]);

        // round-robin fairness, threads 2 and 9 re-requested after done
        base = seen_q.size();
        req(2); req(9);
        for (int c = 0; c < 60; c++) begin
            if (done_en) begin
                req_en = 1'b1;
                req_thread_num = done_thread_num;
            end else begin
                req_en = 1'b0;
            end
            tick();
        end
        req_en = 1'b0;
        wait_idle(50);
        check("rr_enough_outputs", seen_q.size() - base >= 8, 1);
        for (int k = base + 1; k < seen_q.size(); k++)
            check("rr_alternate", seen_q[k] != seen_q[k - 1], 1);

        // backpressure with 8 pending threads
        base = seen_q.size();
        out_ready = 1'b0;
        req(1); req(3); req(5); req(6); req(8); req(10); req(12); req(14);
        repeat (6) tick();
        check("bp_out_valid", out_valid, 1);
        head0 = int'(out_thread_num);
        repeat (5) tick();
        check("bp_head_stable", out_thread_num, head0);
        check("bp_busy", busy, 1);
        out_ready = 1'b1;
        wait_idle(80);
        check("bp_drain_count", seen_q.size() - base, 8);

        // duplicate requests for thread 4
        base = seen_q.size();
        check("dup_err_before", err, 0);
        req(4); req(4);
        for (int k = 0; k < 20; k++) begin
            if (out_valid && out_thread_num == 4'd4) break;
            tick();
        end
        check("dup_head_is_4", out_thread_num, 4);
        req(4);
        wait_idle(50);
        check("dup_err_after", err, 1);
        cnt4 = 0;
        for (int k = base; k < seen_q.size(); k++) if (seen_q[k] == 4) cnt4++;
        check("dup_single_output", cnt4, 1);

        // async reset with work queued and in flight
        out_ready = 1'b0;
        req(1); req(2); req(3); req(4); req(5);
        tick();
        check("pre_reset_busy", busy, 1);
        RST_N = 1'b0;
        #1;
        check_zero_outputs("midreset");
        out_ready = 1'b1;
        tick(); tick();
        check("midreset_no_done", done_en, 0);
        RST_N = 1'b1;
        tick();
        check("post_reset_done_en", done_en, 0);
        base = seen_q.size();
        req(0);
        wait_idle(50);
        check("post_reset_count", seen_q.size() - base, 1);
        if (seen_q.size() - base == 1) check("post_reset_thread", seen_q[base], 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_en = ($urandom_range(0, 2) != 0);
            req_thread_num = 4'($urandom_range(0, NT - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            x = $urandom_range(0, NT - 1);
            if (!m_pend[x] && !m_infl[x] && !(req_en && int'(req_thread_num) == x))
                mem[x] = $urandom;
            tick();
        end
        req_en = 1'b0;
        out_ready = 1'b1;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
